// File: rtl/dsqw_irq_pkg.sv
// Shared event codes, FSM encoding and priority pick for the deskew IRQ service agent.
package dsqw_irq_pkg;

  localparam logic [1:0] EVT_NONE     = 2'd0;
  localparam logic [1:0] EVT_DONE     = 2'd1;
  localparam logic [1:0] EVT_ERR_SIZE = 2'd2;
  localparam logic [1:0] EVT_MEM_ERR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REPORT   = 2'd1,
    ACK      = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  // Memory error outranks size error, which outranks DONE.
  function automatic logic [1:0] pick_evt(input logic done, input logic size_err,
                                          input logic mem_err);
    logic [1:0] code;
    code = EVT_NONE;
    if (mem_err)       code = EVT_MEM_ERR;
    else if (size_err) code = EVT_ERR_SIZE;
    else if (done)     code = EVT_DONE;
    return code;
  endfunction

endpackage

// File: rtl/dsqw_sat_cnt.sv
// Saturating up-counter with a synchronous clear that takes precedence over increment.
module dsqw_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dsqw_irq_handler.sv
// Services deskew IRQ status flags one event at a time: report, ack, wait for clear.
// Optional WAIT_CLR timeout enabled by defining DSQW_IRQ_TIMEOUT_EN.
module dsqw_irq_handler
  import dsqw_irq_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dsqw_irq,
  input  logic             dsqw_done_in,
  input  logic             err_size_in,
  input  logic             mem_acc_err_in,
  output logic             dsqw_done_ack,
  output logic             err_size_ack,
  output logic             mem_acc_err_ack,
  output logic             evt_valid,
  output logic [1:0]       evt_code,
  input  logic             evt_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_done,
  output logic [CNT_W-1:0] cnt_err_size,
  output logic [CNT_W-1:0] cnt_mem_err,
  output logic             busy,
  output logic             timeout_err
);

  state_t     state;
  logic [1:0] det_code;
  logic       sel_flag;
  logic       accept;
  logic       timeout_hit;
  logic [2:0] inc_vec;
  logic [CNT_W-1:0] cnt_arr [3];

  assign det_code = pick_evt(dsqw_done_in, err_size_in, mem_acc_err_in);
  assign accept   = (state == REPORT) && evt_valid && evt_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    sel_flag = 1'b0;
    case (evt_code)
      EVT_DONE:     sel_flag = dsqw_done_in;
      EVT_ERR_SIZE: sel_flag = err_size_in;
      EVT_MEM_ERR:  sel_flag = mem_acc_err_in;
      default:      sel_flag = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      evt_valid       <= 1'b0;
      evt_code        <= EVT_NONE;
      dsqw_done_ack   <= 1'b0;
      err_size_ack    <= 1'b0;
      mem_acc_err_ack <= 1'b0;
    end else begin
      dsqw_done_ack   <= 1'b0;
      err_size_ack    <= 1'b0;
      mem_acc_err_ack <= 1'b0;
      case (state)
        IDLE: begin
          // irq lags the flags by a cycle, so an all-zero status is a stale request.
          if (dsqw_irq && (det_code != EVT_NONE)) begin
            evt_code  <= det_code;
            evt_valid <= 1'b1;
            state     <= REPORT;
          end
        end
        REPORT: begin
          if (accept) begin
            evt_valid       <= 1'b0;
            dsqw_done_ack   <= (evt_code == EVT_DONE);
            err_size_ack    <= (evt_code == EVT_ERR_SIZE);
            mem_acc_err_ack <= (evt_code == EVT_MEM_ERR);
            state           <= ACK;
          end
        end
        ACK: begin
          state <= WAIT_CLR;
        end
        WAIT_CLR: begin
          if (!sel_flag || timeout_hit) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DSQW_IRQ_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Fires on the TIMEOUT-th WAIT_CLR cycle with the flag still pending.
  assign timeout_hit = (state == WAIT_CLR) && sel_flag && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ACK) begin
        to_cnt <= '0;
      end else if (state == WAIT_CLR) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (cnt_clr) begin
        timeout_err <= 1'b0;
      end else if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      assign inc_vec[gi] = accept && (evt_code == 2'(gi + 1));
      dsqw_sat_cnt #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (inc_vec[gi]),
        .cnt   (cnt_arr[gi])
      );
    end
  endgenerate

  assign cnt_done     = cnt_arr[0];
  assign cnt_err_size = cnt_arr[1];
  assign cnt_mem_err  = cnt_arr[2];

endmodule

// File: tb/tb_dsqw_irq_handler.sv
// Self-checking bench for dsqw_irq_handler: transaction-level model, directed cases, random traffic.
module tb_dsqw_irq_handler;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int TO_W    = 7;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dsqw_irq = 1'b0;
  logic done_f = 1'b0, size_f = 1'b0, mem_f = 1'b0;
  logic evt_ready = 1'b0;
  logic cnt_clr = 1'b0;
  logic dsqw_done_ack, err_size_ack, mem_acc_err_ack;
  logic evt_valid, busy, timeout_err;
  logic [1:0] evt_code;
  logic [CNT_W-1:0] cnt_done, cnt_err_size, cnt_mem_err;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  bit hold_flags = 1'b0;
  int ack_seen[3];

  // Model: which event is in flight (0 = none), whether the consumer took it,
  // whether this cycle carries its ack, and per-code serviced counts.
  int m_code;
  bit m_acc, m_ack, m_to;
  int m_wait;
  int m_cnt[4];

  dsqw_irq_handler #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dsqw_irq        (dsqw_irq),
    .dsqw_done_in    (done_f),
    .err_size_in     (size_f),
    .mem_acc_err_in  (mem_f),
    .dsqw_done_ack   (dsqw_done_ack),
    .err_size_ack    (err_size_ack),
    .mem_acc_err_ack (mem_acc_err_ack),
    .evt_valid       (evt_valid),
    .evt_code        (evt_code),
    .evt_ready       (evt_ready),
    .cnt_clr         (cnt_clr),
    .cnt_done        (cnt_done),
    .cnt_err_size    (cnt_err_size),
    .cnt_mem_err     (cnt_mem_err),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_code = 0; m_acc = 1'b0; m_ack = 1'b0; m_to = 1'b0; m_wait = 0;
    for (int c = 0; c < 4; c++) m_cnt[c] = 0;
  endfunction

  function automatic void model_step();
    bit f[4];
    bit was_ack;
    f = '{1'b0, done_f, size_f, mem_f};
    was_ack = m_ack;
    m_ack = 1'b0;
    if (m_code == 0) begin
      if (dsqw_irq && (done_f || size_f || mem_f)) begin
        for (int c = 1; c <= 3; c++) if (f[c]) m_code = c;
        m_acc = 1'b0;
      end
    end else if (!m_acc) begin
      if (evt_ready) begin
        m_acc = 1'b1; m_ack = 1'b1; m_wait = 0;
        if (m_cnt[m_code] < CMAX) m_cnt[m_code]++;
      end
    end else if (was_ack) begin
      m_wait = 0;
    end else if (!f[m_code]) begin
      m_code = 0;
    end else begin
      m_wait++;
`ifdef DSQW_IRQ_TIMEOUT_EN
      if (m_wait == TIMEOUT) begin
        m_to = 1'b1;
        m_code = 0;
      end
`endif
    end
    if (cnt_clr) begin
      for (int c = 0; c < 4; c++) m_cnt[c] = 0;
      m_to = 1'b0;
    end
  endfunction

  // One clock: model follows the edge, then the flag source reacts to the ack
  // that was on the wires during the cycle just ended.
  task automatic tick();
    bit [2:0] old_f, old_a;
    @(posedge clk);
    old_f = {mem_f, size_f, done_f};
    old_a = m_ack ? 3'(1 << (m_code - 1)) : 3'b000;
    if (rst_n) model_step();
    #1;
    dsqw_irq = |old_f;
    if (!hold_flags) {mem_f, size_f, done_f} = old_f & ~old_a;
    ack_seen[0] += int'(dsqw_done_ack);
    ack_seen[1] += int'(err_size_ack);
    ack_seen[2] += int'(mem_acc_err_ack);
  endtask

  task automatic wait_valid(input bit level, input string name);
    for (int i = 0; i < 40 && (evt_valid != level); i++) tick();
    check(name, int'(evt_valid), int'(level));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), int'(m_code != 0));
      check("evt_valid", int'(evt_valid), int'(m_code != 0 && !m_acc));
      if (m_code != 0 && !m_acc) check("evt_code", int'(evt_code), m_code);
      check("done_ack", int'(dsqw_done_ack), int'(m_ack && m_code == 1));
      check("size_ack", int'(err_size_ack), int'(m_ack && m_code == 2));
      check("mem_ack", int'(mem_acc_err_ack), int'(m_ack && m_code == 3));
      check("cnt_done", int'(cnt_done), m_cnt[1]);
      check("cnt_err_size", int'(cnt_err_size), m_cnt[2]);
      check("cnt_mem_err", int'(cnt_mem_err), m_cnt[3]);
      check("timeout_err", int'(timeout_err), int'(m_to));
    end
  end

  initial begin
    int base0, base1, base2, n;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(evt_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_acks", int'({dsqw_done_ack, err_size_ack, mem_acc_err_ack}), 0);
    check("rst_cnts", int'(cnt_done) + int'(cnt_err_size) + int'(cnt_mem_err), 0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Two errors pending together: memory error serviced first, then size error.
    evt_ready = 1'b1;
    mem_f = 1'b1; size_f = 1'b1;
    base1 = ack_seen[1]; base2 = ack_seen[2];
    wait_valid(1'b1, "t1_first_valid");
    check("t1_first_code", int'(evt_code), 3);
    wait_valid(1'b0, "t1_first_taken");
    wait_valid(1'b1, "t1_second_valid");
    check("t1_second_code", int'(evt_code), 2);
    repeat (8) tick();
    check("t1_mem_acks", ack_seen[2] - base2, 1);
    check("t1_size_acks", ack_seen[1] - base1, 1);
    check("t1_cnt_mem", int'(cnt_mem_err), 1);
    check("t1_cnt_size", int'(cnt_err_size), 1);

    // DONE held off by a stalled consumer.
    evt_ready = 1'b0;
    done_f = 1'b1;
    base0 = ack_seen[0];
    wait_valid(1'b1, "t2_valid");
    repeat (5) begin
      tick();
      check("t2_hold_valid", int'(evt_valid), 1);
      check("t2_hold_code", int'(evt_code), 1);
      check("t2_no_ack", int'(dsqw_done_ack), 0);
    end
    evt_ready = 1'b1;
    repeat (8) tick();
    check("t2_done_acks", ack_seen[0] - base0, 1);
    check("t2_cnt_done", int'(cnt_done), 1);

    // Saturation, then clear colliding with an increment.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    repeat (17) begin
      done_f = 1'b1;
      repeat (8) tick();
    end
    check("t3_saturated", int'(cnt_done), CMAX);
    done_f = 1'b1;
    wait_valid(1'b1, "t3_valid");
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("t3_clr_wins", int'(cnt_done), 0);
    repeat (6) tick();

    // Flag that never clears.
    hold_flags = 1'b1;
    size_f = 1'b1;
`ifdef DSQW_IRQ_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 100 && !timeout_err; i++) begin
      tick();
      n++;
    end
    check("t4_timeout_cycles", n, 68);
    check("t4_timeout_err", int'(timeout_err), 1);
    check("t4_idle", int'(busy), 0);
`else
    n = 0;
    repeat (80) tick();
    check("t4_still_busy", int'(busy), 1);
    check("t4_timeout_err", int'(timeout_err), n);
`endif
    size_f = 1'b0;
    hold_flags = 1'b0;
    tick();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    repeat (4) tick();

    // Reset while an event is being reported.
    evt_ready = 1'b0;
    done_f = 1'b1;
    wait_valid(1'b1, "t5_valid");
    base0 = ack_seen[0];
    #2 rst_n = 1'b0;
    #1;
    check("t5_valid_cleared", int'(evt_valid), 0);
    check("t5_busy_cleared", int'(busy), 0);
    check("t5_acks_cleared", int'({dsqw_done_ack, err_size_ack, mem_acc_err_ack}), 0);
    check("t5_cnt_cleared", int'(cnt_done) + int'(cnt_err_size) + int'(cnt_mem_err), 0);
    model_reset();
    done_f = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    evt_ready = 1'b1;
    repeat (4) tick();
    check("t5_no_ack", ack_seen[0] - base0, 0);
    check("t5_idle", int'(busy), 0);

    // Stale irq with no status bits.
    dsqw_irq = 1'b1;
    tick();
    check("t6_no_valid", int'(evt_valid), 0);
    check("t6_not_busy", int'(busy), 0);
    tick();
    check("t6_no_valid2", int'(evt_valid), 0);
    check("t6_not_busy2", int'(busy), 0);

    // Random traffic.
    repeat (3000) begin
      if ($urandom_range(7) == 0) done_f = 1'b1;
      if ($urandom_range(9) == 0) size_f = 1'b1;
      if ($urandom_range(11) == 0) mem_f = 1'b1;
      evt_ready = ($urandom_range(9) < 7);
      cnt_clr = ($urandom_range(59) == 0);
      tick();
    end
    cnt_clr = 1'b0;
    evt_ready = 1'b1;
    repeat (20) tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
